// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the bypassing register file and its clear engine.
package regfile_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE
    } clr_state_e;

    localparam int XLEN_D = 32;
    localparam int NREG_D = 32;

endpackage

// File: rtl/regfile_clr_fsm.sv
// Sequential bulk-clear engine: walks an index over every register, then pulses done.
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int NREG = NREG_D,
    localparam int AW = $clog2(NREG)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_req,
    output logic          clr_en,
    output logic [AW-1:0] clr_idx,
    output logic          idle,
    output logic          busy,
    output logic          done
);

    localparam logic [AW:0] LAST_IDX = (AW+1)'(NREG - 1);

    clr_state_e  state;
    logic [AW:0] idx;

    // Busy and done are registered alongside the state so they never glitch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (clr_req) begin
                        state <= CLEAR;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    idx <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign clr_en  = (state == CLEAR);
    assign idle    = (state == IDLE);
    assign clr_idx = idx[AW-1:0];

endmodule

// File: rtl/regfile_bypass_sb.sv
// Multi-read-port register file with write-to-read bypass, pending scoreboard
// and a sequential bulk-clear engine.
module regfile_bypass_sb
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_D,
    parameter int NREG     = NREG_D,
    parameter int NRD      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW = $clog2(NREG)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NRD*AW-1:0]   rs_addr_i,
    output logic [NRD*XLEN-1:0] rs_data_o,
    output logic [NRD-1:0]      rs_pend_o,
    input  logic                rd_wren_i,
    input  logic [AW-1:0]       rd_addr_i,
    input  logic [XLEN-1:0]     rd_data_i,
    input  logic                iss_valid_i,
    input  logic [AW-1:0]       iss_addr_i,
    input  logic                clr_req_i,
    output logic                clr_busy_o,
    output logic                clr_done_o
);

    logic [XLEN-1:0] mem [NREG];
    logic [NREG-1:0] pend;

    logic          clr_en;
    logic [AW-1:0] clr_idx;
    logic          fsm_idle;
    logic          wr_ok;
    logic          iss_ok;

    regfile_clr_fsm #(
        .NREG (NREG)
    ) u_clr_fsm (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_req (clr_req_i),
        .clr_en  (clr_en),
        .clr_idx (clr_idx),
        .idle    (fsm_idle),
        .busy    (clr_busy_o),
        .done    (clr_done_o)
    );

    assign wr_ok  = rd_wren_i   && !((ZERO_REG != 0) && (rd_addr_i  == '0));
    assign iss_ok = iss_valid_i && !((ZERO_REG != 0) && (iss_addr_i == '0));

    // The set is applied after the clear so a same-cycle issue keeps the register pending.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
            pend <= '0;
        end else if (clr_en) begin
            mem[clr_idx]  <= '0;
            pend[clr_idx] <= 1'b0;
        end else if (fsm_idle) begin
            if (wr_ok) begin
                mem[rd_addr_i] <= rd_data_i;
            end
            if (rd_wren_i) begin
                pend[rd_addr_i] <= 1'b0;
            end
            if (iss_ok) begin
                pend[iss_addr_i] <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] sel;
        logic          byp;

        assign sel = rs_addr_i[k*AW +: AW];
        assign byp = (BYPASS != 0) && fsm_idle && rd_wren_i && (rd_addr_i == sel)
                     && !((ZERO_REG != 0) && (sel == '0));
        assign rs_data_o[k*XLEN +: XLEN] = byp ? rd_data_i : mem[sel];
        assign rs_pend_o[k]              = byp ? 1'b0 : pend[sel];
    end

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Directed bench for regfile_bypass_sb: default 32x32 instance plus a 3-port 16x64 instance.
module tb_regfile_bypass_sb;
    import regfile_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [9:0]  rs_addr;
    logic [63:0] rs_data;
    logic [1:0]  rs_pend;
    logic        rd_wren;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic        clr_req;
    logic        clr_busy;
    logic        clr_done;

    logic [11:0]  rs_addr2;
    logic [191:0] rs_data2;
    logic [2:0]   rs_pend2;
    logic         rd_wren2;
    logic [3:0]   rd_addr2;
    logic [63:0]  rd_data2;
    logic         clr_req2;
    logic         clr_busy2;
    logic         clr_done2;

    int checks   = 0;
    int failures = 0;
    int busy_cycles;
    int done_cnt;

    always #5 clk_i = ~clk_i;

    regfile_bypass_sb dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .rs_addr_i   (rs_addr),
        .rs_data_o   (rs_data),
        .rs_pend_o   (rs_pend),
        .rd_wren_i   (rd_wren),
        .rd_addr_i   (rd_addr),
        .rd_data_i   (rd_data),
        .iss_valid_i (iss_valid),
        .iss_addr_i  (iss_addr),
        .clr_req_i   (clr_req),
        .clr_busy_o  (clr_busy),
        .clr_done_o  (clr_done)
    );

    regfile_bypass_sb #(
        .XLEN     (64),
        .NREG     (16),
        .NRD      (3),
        .BYPASS   (1),
        .ZERO_REG (0)
    ) dut2 (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .rs_addr_i   (rs_addr2),
        .rs_data_o   (rs_data2),
        .rs_pend_o   (rs_pend2),
        .rd_wren_i   (rd_wren2),
        .rd_addr_i   (rd_addr2),
        .rd_data_i   (rd_data2),
        .iss_valid_i (1'b0),
        .iss_addr_i  (4'd0),
        .clr_req_i   (clr_req2),
        .clr_busy_o  (clr_busy2),
        .clr_done_o  (clr_done2)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic wren, input logic [4:0] waddr, input logic [31:0] wdata,
                                 input logic iss, input logic [4:0] iaddr,
                                 input logic [4:0] a0, input logic [4:0] a1);
        rd_wren   = wren;
        rd_addr   = waddr;
        rd_data   = wdata;
        iss_valid = iss;
        iss_addr  = iaddr;
        rs_addr   = {a1, a0};
        #1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] fill_val(input int a);
        return 32'(a) * 32'h0101_0101 + 32'd1;
    endfunction

    initial begin
        rst_ni   = 1'b0;
        clr_req  = 1'b0;
        rd_wren2 = 1'b0;
        rd_addr2 = '0;
        rd_data2 = '0;
        rs_addr2 = '0;
        clr_req2 = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        checkOutput("rst_busy", 64'(clr_busy), 64'd0);
        checkOutput("rst_done", 64'(clr_done), 64'd0);
        tick();
        rst_ni = 1'b1;

        for (int a = 0; a < 32; a++) begin
            applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'(a), 5'(31 - a));
            checkOutput("reset_rd0", rs_data[31:0], 64'd0);
            checkOutput("reset_rd1", rs_data[63:32], 64'd0);
            checkOutput("reset_pend", 64'(rs_pend), 64'd0);
        end
        checkOutput("idle_busy", 64'(clr_busy), 64'd0);

        // Write x5 with port0 reading x5 in the same cycle
        applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd5, 5'd0);
        checkOutput("bypass_x5", rs_data[31:0], 64'hDEAD_BEEF);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd5);
        checkOutput("stored_x5_p0", rs_data[31:0], 64'hDEAD_BEEF);
        checkOutput("stored_x5_p1", rs_data[63:32], 64'hDEAD_BEEF);
        tick();
        checkOutput("stored_x5_later", rs_data[31:0], 64'hDEAD_BEEF);

        applyStimulus(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 5'd0, 5'd0);
        checkOutput("x0_no_bypass", rs_data[31:0], 64'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        checkOutput("x0_zero", rs_data[31:0], 64'd0);

        // Scoreboard on x7
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd7);
        checkOutput("iss_same_cycle", 64'(rs_pend), 64'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd7);
        checkOutput("iss_pending", 64'(rs_pend), 64'd3);
        applyStimulus(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 5'd7, 5'd6);
        checkOutput("wb_pend_forced", 64'(rs_pend), 64'd0);
        checkOutput("wb_bypass_x7", rs_data[31:0], 64'h77);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd7);
        checkOutput("wb_released", 64'(rs_pend), 64'd0);
        checkOutput("wb_data_x7", rs_data[63:32], 64'h77);
        applyStimulus(1'b1, 5'd7, 32'h99, 1'b1, 5'd7, 5'd7, 5'd7);
        checkOutput("set_clr_cycle", 64'(rs_pend), 64'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd3);
        checkOutput("set_wins", 64'(rs_pend), 64'd1);
        checkOutput("set_wins_data", rs_data[31:0], 64'h99);

        // Fill x1..x31 then clear the whole file
        for (int a = 1; a < 32; a++) begin
            applyStimulus(1'b1, 5'(a), fill_val(a), 1'b0, 5'd0, 5'd0, 5'd0);
            tick();
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd31, 5'd17);
        checkOutput("fill_x31", rs_data[31:0], 64'(fill_val(31)));
        checkOutput("fill_x17", rs_data[63:32], 64'(fill_val(17)));
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        busy_cycles = 0;
        done_cnt    = 0;
        applyStimulus(1'b1, 5'd3, 32'hFF, 1'b1, 5'd3, 5'd3, 5'd0);
        checkOutput("busy_no_bypass", rs_data[31:0], 64'(fill_val(3)));
        while (clr_busy && busy_cycles < 100) begin
            if (clr_done) done_cnt++;
            busy_cycles++;
            tick();
            applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd0);
        end
        checkOutput("clr_busy_len", 64'(busy_cycles), 64'd33);
        checkOutput("clr_done_cnt", 64'(done_cnt), 64'd1);
        checkOutput("clr_done_low", 64'(clr_done), 64'd0);
        checkOutput("busy_write_drop", rs_data[31:0], 64'd0);
        for (int a = 0; a < 32; a++) begin
            applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'(a), 5'(a));
            checkOutput("cleared_rd", rs_data[31:0], 64'd0);
            checkOutput("cleared_pend", 64'(rs_pend), 64'd0);
        end

        // Reset asserted during the tenth clear cycle
        applyStimulus(1'b1, 5'd20, 32'hABCD, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        applyStimulus(1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd20, 5'd2);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (9) tick();
        checkOutput("midclr_busy", 64'(clr_busy), 64'd1);
        checkOutput("midclr_x20", rs_data[31:0], 64'hABCD);
        checkOutput("midclr_x2", rs_data[63:32], 64'd0);
        rst_ni = 1'b0;
        #1;
        checkOutput("abort_busy", 64'(clr_busy), 64'd0);
        checkOutput("abort_done", 64'(clr_done), 64'd0);
        checkOutput("abort_x20", rs_data[31:0], 64'd0);
        tick();
        checkOutput("abort_done_held", 64'(clr_done), 64'd0);
        rst_ni = 1'b1;
        tick();
        checkOutput("abort_done_after", 64'(clr_done), 64'd0);
        checkOutput("abort_idle_busy", 64'(clr_busy), 64'd0);

        // Second instance: 3 ports, 16 entries, 64-bit, x0 writable
        rd_wren2 = 1'b1;
        rd_addr2 = 4'd0;
        rd_data2 = 64'hA5A5_A5A5_A5A5_A5A5;
        rs_addr2 = {4'd2, 4'd1, 4'd0};
        #1;
        checkOutput("p2_x0_bypass", rs_data2[63:0], 64'hA5A5_A5A5_A5A5_A5A5);
        tick();
        rd_addr2 = 4'd1;
        rd_data2 = 64'h1111_2222_3333_4444;
        tick();
        rd_addr2 = 4'd15;
        rd_data2 = 64'hF0E1_D2C3_B4A5_9687;
        tick();
        rd_wren2 = 1'b0;
        rs_addr2 = {4'd15, 4'd1, 4'd0};
        #1;
        checkOutput("p2_x0", rs_data2[63:0], 64'hA5A5_A5A5_A5A5_A5A5);
        checkOutput("p2_x1", rs_data2[127:64], 64'h1111_2222_3333_4444);
        checkOutput("p2_x15", rs_data2[191:128], 64'hF0E1_D2C3_B4A5_9687);
        rs_addr2 = {4'd0, 4'd15, 4'd1};
        #1;
        checkOutput("p2_swap0", rs_data2[63:0], 64'h1111_2222_3333_4444);
        checkOutput("p2_swap2", rs_data2[191:128], 64'hA5A5_A5A5_A5A5_A5A5);
        clr_req2 = 1'b1;
        tick();
        clr_req2 = 1'b0;
        busy_cycles = 0;
        done_cnt    = 0;
        while (clr_busy2 && busy_cycles < 100) begin
            if (clr_done2) done_cnt++;
            busy_cycles++;
            tick();
        end
        checkOutput("p2_busy_len", 64'(busy_cycles), 64'd17);
        checkOutput("p2_done_cnt", 64'(done_cnt), 64'd1);
        rs_addr2 = {4'd15, 4'd1, 4'd0};
        #1;
        checkOutput("p2_clr_x0", rs_data2[63:0], 64'd0);
        checkOutput("p2_clr_x15", rs_data2[191:128], 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
